// File: rtl/simple_st0_mem_ctrl_if.sv
//==============================================================================
// Module      : simple_st0_mem_ctrl_if
// Description : Interface for the st0 memory controller. It carries the load
//               stream, the job controls, the tap/bias/data memory ports and
//               the beat stream to the compute datapath. The master modport
//               is the controller side and the slave modport is the side that
//               holds the memories and the datapath.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface simple_st0_mem_ctrl_if #(
    parameter int TAP_W   = 192,
    parameter int DATA_W  = 32,
    parameter int TAP_AW  = 5,
    parameter int BIAS_AW = 4,
    parameter int DATA_AW = 6
);
    // Load stream
    logic                ld_valid;
    logic                ld_ready;
    logic [1:0]          ld_sel;
    logic [TAP_AW:0]     ld_addr;
    logic [TAP_W-1:0]    ld_data;

    // Job control
    logic                start;
    logic [BIAS_AW-1:0]  num_out;
    logic [DATA_AW-1:0]  num_step;
    logic                busy;
    logic                done;

    // Memory ports
    logic [TAP_AW-1:0]   tap_addr;
    logic                tap_wr_en;
    logic                tap_rd_en;
    logic [TAP_W-1:0]    tap_wr_data;
    logic [TAP_W-1:0]    tap_rd_data;
    logic [BIAS_AW-1:0]  bias_addr;
    logic                bias_wr_en;
    logic                bias_rd_en;
    logic [DATA_W-1:0]   bias_wr_data;
    logic [DATA_W-1:0]   bias_rd_data;
    logic [DATA_AW-1:0]  data_addr;
    logic                data_wr_en;
    logic                data_rd_en;
    logic [DATA_W-1:0]   data_wr_data;
    logic [DATA_W-1:0]   data_rd_data;

    // Beat stream towards the datapath
    logic                out_valid;
    logic                out_ready;
    logic [TAP_W-1:0]    out_tap;
    logic [DATA_W-1:0]   out_data;
    logic [DATA_W-1:0]   out_bias;
    logic                out_first;
    logic                out_last;

    modport master (
        input  ld_valid, ld_sel, ld_addr, ld_data,
        input  start, num_out, num_step,
        input  tap_rd_data, bias_rd_data, data_rd_data,
        input  out_ready,
        output ld_ready, busy, done,
        output tap_addr, tap_wr_en, tap_rd_en, tap_wr_data,
        output bias_addr, bias_wr_en, bias_rd_en, bias_wr_data,
        output data_addr, data_wr_en, data_rd_en, data_wr_data,
        output out_valid, out_tap, out_data, out_bias, out_first, out_last
    );

    modport slave (
        output ld_valid, ld_sel, ld_addr, ld_data,
        output start, num_out, num_step,
        output tap_rd_data, bias_rd_data, data_rd_data,
        output out_ready,
        input  ld_ready, busy, done,
        input  tap_addr, tap_wr_en, tap_rd_en, tap_wr_data,
        input  bias_addr, bias_wr_en, bias_rd_en, bias_wr_data,
        input  data_addr, data_wr_en, data_rd_en, data_wr_data,
        input  out_valid, out_tap, out_data, out_bias, out_first, out_last
    );
endinterface

`default_nettype wire

// File: rtl/simple_st0_mem_ctrl.sv
//==============================================================================
// Module      : simple_st0_mem_ctrl
// Description : Initiator for the st0 tap/bias/data memories. In IDLE it
//               forwards a load stream into the memories; in RUN it sequences
//               reads (bias once per output, tap+data per step) and emits
//               aligned {tap, data, bias} beats on a valid/ready stream.
//               Optional macro SIMPLE_ST0_MEM_CTRL_PERF_EN adds a saturating
//               output stall counter (stall_cnt).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module simple_st0_mem_ctrl #(
    parameter int TAP_W   = 192,
    parameter int DATA_W  = 32,
    parameter int TAP_AW  = 5,
    parameter int BIAS_AW = 4,
    parameter int DATA_AW = 6
) (
    input  wire                   clk,
    input  wire                   reset,
    simple_st0_mem_ctrl_if.master bus
`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // One buffered beat: {tap, data, bias, first, last}
    localparam int ENTRY_W = TAP_W + 2 * DATA_W + 2;

    logic [1:0]          state;
    logic                done_q;

    logic [BIAS_AW-1:0]  num_out_q;
    logic [DATA_AW-1:0]  num_step_q;
    logic [BIAS_AW-1:0]  o_cnt;
    logic [DATA_AW-1:0]  s_cnt;
    logic [TAP_AW-1:0]   t_cnt;

    // Side information for the read issued in the previous cycle
    logic                inflight;
    logic                pend_bias;
    logic                pend_first;
    logic                pend_last;
    logic [DATA_W-1:0]   bias_hold;

    logic [ENTRY_W-1:0]  fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_count;

    logic                load;
    logic                start_take;
    logic                pop;
    logic                push;
    logic [1:0]          occupancy;
    logic                issue;
    logic                last_issue;
    logic                drain_exit;
    logic [DATA_W-1:0]   cap_bias;
    logic [ENTRY_W-1:0]  cap_entry;
    logic [ENTRY_W-1:0]  head;

    // Control decode; a slot freed by a pop this cycle is reusable at once,
    // which is what sustains one beat per cycle with a 2-entry buffer.
    always_comb begin
        load       = (state == IDLE) && bus.ld_valid;
        start_take = (state == IDLE) && bus.start;
        pop        = (fifo_count != 2'd0) && bus.out_ready;
        push       = inflight;
        occupancy  = fifo_count + {1'b0, inflight} - {1'b0, pop};
        issue      = (state == RUN) && (occupancy < 2'd2);
        last_issue = issue && (o_cnt == num_out_q) && (s_cnt == num_step_q);
        drain_exit = !inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));
        cap_bias   = pend_bias ? bus.bias_rd_data : bias_hold;
        cap_entry  = {bus.tap_rd_data, bus.data_rd_data, cap_bias, pend_first, pend_last};
        head       = fifo_mem[rd_ptr];
    end

    // Memory port drive: load writes in IDLE, sequenced reads in RUN
    always_comb begin
        bus.ld_ready     = (state == IDLE);
        bus.tap_wr_en    = load && (bus.ld_sel == 2'd0);
        bus.bias_wr_en   = load && (bus.ld_sel == 2'd1);
        bus.data_wr_en   = load && (bus.ld_sel == 2'd2);
        bus.tap_rd_en    = issue;
        bus.data_rd_en   = issue;
        bus.bias_rd_en   = issue && (s_cnt == '0);
        bus.tap_wr_data  = load ? bus.ld_data : '0;
        bus.bias_wr_data = load ? bus.ld_data[DATA_W-1:0] : '0;
        bus.data_wr_data = load ? bus.ld_data[DATA_W-1:0] : '0;
        bus.tap_addr     = '0;
        bus.bias_addr    = '0;
        bus.data_addr    = '0;
        if (issue) begin
            bus.tap_addr  = t_cnt;
            bus.data_addr = s_cnt;
            if (s_cnt == '0) begin
                bus.bias_addr = o_cnt;
            end
        end else if (load) begin
            bus.tap_addr  = bus.ld_addr[TAP_AW-1:0];
            bus.bias_addr = bus.ld_addr[BIAS_AW-1:0];
            bus.data_addr = bus.ld_addr[DATA_AW-1:0];
        end
    end

    // Beat stream and status outputs come straight from the buffer head
    always_comb begin
        bus.out_valid = (fifo_count != 2'd0);
        {bus.out_tap, bus.out_data, bus.out_bias, bus.out_first, bus.out_last} = head;
        bus.busy      = (state != IDLE);
        bus.done      = done_q;
    end

    // Job state machine; done pulses in the first IDLE cycle after a job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Job geometry latch and output/step/tap counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_out_q  <= '0;
            num_step_q <= '0;
            o_cnt      <= '0;
            s_cnt      <= '0;
            t_cnt      <= '0;
        end else if (start_take) begin
            num_out_q  <= bus.num_out;
            num_step_q <= bus.num_step;
            o_cnt      <= '0;
            s_cnt      <= '0;
            t_cnt      <= '0;
        end else if (issue) begin
            t_cnt <= t_cnt + 1'b1;
            if (s_cnt == num_step_q) begin
                s_cnt <= '0;
                o_cnt <= o_cnt + 1'b1;
            end else begin
                s_cnt <= s_cnt + 1'b1;
            end
        end
    end

    // Track the outstanding read and the bias for the current output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight   <= 1'b0;
            pend_bias  <= 1'b0;
            pend_first <= 1'b0;
            pend_last  <= 1'b0;
            bias_hold  <= '0;
        end else begin
            inflight   <= issue;
            pend_bias  <= issue && (s_cnt == '0);
            pend_first <= (s_cnt == '0);
            pend_last  <= (s_cnt == num_step_q);
            if (inflight && pend_bias) begin
                bias_hold <= bus.bias_rd_data;
            end
        end
    end

    // Two-entry return buffer, written one cycle after each issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= cap_entry;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
    // Count cycles where a beat waits on the datapath during a job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (start_take) begin
            stall_cnt <= 16'd0;
        end else if ((state != IDLE) && (fifo_count != 2'd0) && !bus.out_ready
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_st0_mem_ctrl.sv
//==============================================================================
// Module      : tb_simple_st0_mem_ctrl
// Description : Directed self-checking bench for simple_st0_mem_ctrl with a
//               behavioural model of the three memories (1-cycle read).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_simple_st0_mem_ctrl;

    localparam int TAP_W     = 192;
    localparam int DATA_W    = 32;
    localparam int TAP_AW    = 5;
    localparam int BIAS_AW   = 4;
    localparam int DATA_AW   = 6;
    localparam int PAY_W     = TAP_W + 2 * DATA_W + 2;
    localparam int JOB_LIMIT = 400;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    simple_st0_mem_ctrl_if #(
        .TAP_W(TAP_W), .DATA_W(DATA_W), .TAP_AW(TAP_AW),
        .BIAS_AW(BIAS_AW), .DATA_AW(DATA_AW)
    ) bus ();

`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
    logic [15:0] stall_cnt;
`endif

    simple_st0_mem_ctrl #(
        .TAP_W(TAP_W), .DATA_W(DATA_W), .TAP_AW(TAP_AW),
        .BIAS_AW(BIAS_AW), .DATA_AW(DATA_AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus)
`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read
    logic [TAP_W-1:0]  tap_mem  [32];
    logic [DATA_W-1:0] bias_mem [16];
    logic [DATA_W-1:0] data_mem [64];

    always @(posedge clk) begin
        if (bus.tap_wr_en)  tap_mem[bus.tap_addr]   <= bus.tap_wr_data;
        if (bus.bias_wr_en) bias_mem[bus.bias_addr] <= bus.bias_wr_data;
        if (bus.data_wr_en) data_mem[bus.data_addr] <= bus.data_wr_data;
        if (bus.tap_rd_en)  bus.tap_rd_data  <= tap_mem[bus.tap_addr];
        if (bus.bias_rd_en) bus.bias_rd_data <= bias_mem[bus.bias_addr];
        if (bus.data_rd_en) bus.data_rd_data <= data_mem[bus.data_addr];
    end

    int checks = 0;
    int passed = 0;

    // Results gathered by run_job
    logic [PAY_W-1:0]   got_beat [$];
    logic [TAP_AW-1:0]  iss_tap  [$];
    logic [DATA_AW-1:0] iss_data [$];
    logic [BIAS_AW-1:0] iss_bias [$];
    int   unstable, first_beat_cyc, last_beat_cyc, done_cyc;
    logic timed_out, busy_at_done;
    logic [15:0] stall_at_done;

    function automatic logic [TAP_W-1:0] tap_val(input int i);
        logic [31:0] w;
        w = 32'hCAFE_0000 + 32'(i);
        return {w ^ 32'h5, w ^ 32'h4, w ^ 32'h3, w ^ 32'h2, w ^ 32'h1, w};
    endfunction

    function automatic logic [DATA_W-1:0] bias_val(input int i);
        return 32'hB1A5_0000 + 32'(i);
    endfunction

    function automatic logic [DATA_W-1:0] data_val(input int i);
        return 32'hDA7A_0000 + 32'(i);
    endfunction

    // Beat n of a job: output n/(ns+1), step n%(ns+1), tap address n mod 32
    function automatic logic [PAY_W-1:0] exp_beat(input int n, input int ns);
        int o;
        int s;
        o = n / (ns + 1);
        s = n % (ns + 1);
        return {tap_val(n % 32), data_val(s), bias_val(o), (s == 0), (s == ns)};
    endfunction

    function automatic logic rdy(input int mode, input int cyc);
        if (mode == 1) return (cyc % 2) == 0;
        if (mode == 2) return !(cyc >= 2 && cyc < 12);
        return 1'b1;
    endfunction

    task automatic run_job(input int no, input int ns, input int mode);
        int cyc;
        logic stalled;
        logic [PAY_W-1:0] held;
        logic [PAY_W-1:0] cur;
        got_beat.delete(); iss_tap.delete(); iss_data.delete(); iss_bias.delete();
        unstable = 0; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        timed_out = 1'b0; busy_at_done = 1'b1; stall_at_done = 16'hDEAD;
        stalled = 1'b0; held = '0;
        @(negedge clk);
        bus.num_out = no[BIAS_AW-1:0]; bus.num_step = ns[DATA_AW-1:0];
        bus.start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.num_out = ~no[BIAS_AW-1:0]; bus.num_step = ~ns[DATA_AW-1:0];
        cyc = 0;
        while (done_cyc < 0 && !timed_out) begin
            bus.out_ready = rdy(mode, cyc);
            #1;
            if (bus.tap_rd_en) begin
                iss_tap.push_back(bus.tap_addr);
                iss_data.push_back(bus.data_addr);
            end
            if (bus.bias_rd_en) iss_bias.push_back(bus.bias_addr);
            cur = {bus.out_tap, bus.out_data, bus.out_bias, bus.out_first, bus.out_last};
            if (bus.out_valid) begin
                if (stalled && cur !== held) unstable++;
                if (bus.out_ready) begin
                    got_beat.push_back(cur);
                    if (first_beat_cyc < 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                end
                stalled = !bus.out_ready;
                held = cur;
            end else begin
                if (stalled) unstable++;
                stalled = 1'b0;
            end
            if (bus.done) begin
                done_cyc = cyc;
                busy_at_done = bus.busy;
`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
                stall_at_done = stall_cnt;
`endif
            end else begin
                cyc++;
                if (cyc > JOB_LIMIT) timed_out = 1'b1;
                else @(negedge clk);
            end
        end
        bus.out_ready = 1'b1;
        bus.num_out = '0; bus.num_step = '0;
    endtask

    task automatic fill_memories();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.ld_valid = 1'b1; bus.ld_sel = 2'd0; bus.ld_addr = i[TAP_AW:0]; bus.ld_data = tap_val(i);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.ld_sel = 2'd1; bus.ld_addr = i[TAP_AW:0]; bus.ld_data = {160'd0, bias_val(i)};
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.ld_sel = 2'd2; bus.ld_addr = i[TAP_AW:0]; bus.ld_data = {160'd0, data_val(i)};
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.ld_ready, bus.busy, bus.done, bus.out_valid} !== 4'b1000) begin
            $display("FAIL reset_status got %b exp 1000", {bus.ld_ready, bus.busy, bus.done, bus.out_valid});
        end else passed++;
        checks++;
        if ({bus.tap_rd_en, bus.bias_rd_en, bus.data_rd_en, bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en,
             bus.tap_addr, bus.bias_addr, bus.data_addr} !== '0) begin
            $display("FAIL reset_mem_ports got nonzero enables/addresses");
        end else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.ld_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            $display("FAIL after_reset_status got %b exp 100", {bus.ld_ready, bus.busy, bus.out_valid});
        end else passed++;
    endtask

    task automatic test_load();
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_sel = 2'd0; bus.ld_addr = 6'd3; bus.ld_data = {24{8'hA5}};
        #1;
        checks++;
        if ({bus.tap_wr_en, bus.tap_addr} !== {1'b1, 5'd3} || bus.tap_wr_data !== {24{8'hA5}}) begin
            $display("FAIL load_tap got en=%b addr=%0d data=%h", bus.tap_wr_en, bus.tap_addr, bus.tap_wr_data);
        end else passed++;
        checks++;
        if ({bus.bias_wr_en, bus.data_wr_en, bus.tap_rd_en, bus.bias_rd_en, bus.data_rd_en} !== 5'b0) begin
            $display("FAIL load_tap_others got %b exp 00000",
                     {bus.bias_wr_en, bus.data_wr_en, bus.tap_rd_en, bus.bias_rd_en, bus.data_rd_en});
        end else passed++;
        @(negedge clk);
        bus.ld_sel = 2'd1; bus.ld_addr = 6'd1; bus.ld_data = 192'h10;
        #1;
        checks++;
        if ({bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en, bus.bias_addr, bus.bias_wr_data} !==
            {3'b010, 4'd1, 32'h10}) begin
            $display("FAIL load_bias got en=%b addr=%0d data=%h", {bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en},
                     bus.bias_addr, bus.bias_wr_data);
        end else passed++;
        @(negedge clk);
        bus.ld_sel = 2'd2; bus.ld_addr = 6'd2; bus.ld_data = 192'h7;
        #1;
        checks++;
        if ({bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en, bus.data_addr, bus.data_wr_data} !==
            {3'b001, 6'd2, 32'h7}) begin
            $display("FAIL load_data got en=%b addr=%0d data=%h", {bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en},
                     bus.data_addr, bus.data_wr_data);
        end else passed++;
        @(negedge clk);
        bus.ld_sel = 2'd3; bus.ld_addr = 6'd4;
        #1;
        checks++;
        if ({bus.ld_ready, bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en} !== 4'b1000) begin
            $display("FAIL load_dropped got %b exp 1000", {bus.ld_ready, bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en});
        end else passed++;
        @(negedge clk);
        bus.ld_valid = 1'b0; bus.ld_sel = 2'd2;
        #1;
        checks++;
        if ({bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en} !== 3'b000) begin
            $display("FAIL load_idle got %b exp 000", {bus.tap_wr_en, bus.bias_wr_en, bus.data_wr_en});
        end else passed++;
    endtask

    task automatic test_start_with_load();
        int beats;
        logic seen_done;
        logic [PAY_W-1:0] beat0;
        beats = 0; seen_done = 1'b0; beat0 = '0;
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_sel = 2'd2; bus.ld_addr = 6'd5; bus.ld_data = {160'd0, data_val(5)};
        bus.start = 1'b1; bus.num_out = 4'd0; bus.num_step = 6'd0; bus.out_ready = 1'b1;
        #1;
        checks++;
        if ({bus.data_wr_en, bus.data_addr} !== {1'b1, 6'd5}) begin
            $display("FAIL start_load_write got en=%b addr=%0d", bus.data_wr_en, bus.data_addr);
        end else passed++;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.ld_ready, bus.busy, bus.data_wr_en} !== 3'b010) begin
            $display("FAIL start_load_next got %b exp 010", {bus.ld_ready, bus.busy, bus.data_wr_en});
        end else passed++;
        bus.ld_valid = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (bus.out_valid && bus.out_ready) begin
                if (beats == 0) beat0 = {bus.out_tap, bus.out_data, bus.out_bias, bus.out_first, bus.out_last};
                beats++;
            end
            if (bus.done) seen_done = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        checks++;
        if (!seen_done || beats != 1 || beat0 !== exp_beat(0, 0)) begin
            $display("FAIL start_load_job got done=%b beats=%0d beat=%h exp %h", seen_done, beats, beat0, exp_beat(0, 0));
        end else passed++;
    endtask

    task automatic test_basic();
        int bad;
        run_job(1, 2, 0);
        checks++;
        if (timed_out !== 1'b0 || got_beat.size() != 6) begin
            $display("FAIL basic_count got beats=%0d timeout=%b exp 6", got_beat.size(), timed_out);
        end else passed++;
        for (int i = 0; i < got_beat.size(); i++) begin
            checks++;
            if (got_beat[i] !== exp_beat(i, 2)) $display("FAIL basic_beat[%0d] got %h exp %h", i, got_beat[i], exp_beat(i, 2));
            else passed++;
        end
        bad = (iss_tap.size() == 6) ? 0 : 1;
        for (int i = 0; i < iss_tap.size(); i++) begin
            if (iss_tap[i] !== 5'(i) || iss_data[i] !== 6'(i % 3)) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL basic_issue_addr got %0d bad issues exp 0", bad);
        else passed++;
        checks++;
        if (iss_bias.size() != 2 || iss_bias[0] !== 4'd0 || iss_bias[1] !== 4'd1) begin
            $display("FAIL basic_bias_reads got %0d reads exp 2 at addr 0,1", iss_bias.size());
        end else passed++;
        checks++;
        if (last_beat_cyc - first_beat_cyc != 5) begin
            $display("FAIL basic_back_to_back got span %0d exp 5", last_beat_cyc - first_beat_cyc);
        end else passed++;
        checks++;
        if (done_cyc != last_beat_cyc + 1 || busy_at_done !== 1'b0) begin
            $display("FAIL basic_done got done_cyc=%0d busy=%b exp %0d busy=0", done_cyc, busy_at_done, last_beat_cyc + 1);
        end else passed++;
    endtask

    task automatic test_backpressure();
        int bad;
        run_job(1, 2, 1);
        checks++;
        if (timed_out !== 1'b0 || got_beat.size() != 6) begin
            $display("FAIL bp_count got beats=%0d timeout=%b exp 6", got_beat.size(), timed_out);
        end else passed++;
        bad = 0;
        for (int i = 0; i < got_beat.size(); i++) if (got_beat[i] !== exp_beat(i, 2)) bad++;
        checks++;
        if (bad != 0) $display("FAIL bp_beats got %0d wrong beats exp 0", bad);
        else passed++;
        checks++;
        if (unstable != 0) $display("FAIL bp_stable got %0d unstable stalls exp 0", unstable);
        else passed++;
        checks++;
        if (done_cyc != last_beat_cyc + 1) $display("FAIL bp_done got %0d exp %0d", done_cyc, last_beat_cyc + 1);
        else passed++;
    endtask

    task automatic test_wrap();
        int bad;
        run_job(0, 63, 0);
        checks++;
        if (timed_out !== 1'b0 || got_beat.size() != 64) begin
            $display("FAIL wrap_count got beats=%0d timeout=%b exp 64", got_beat.size(), timed_out);
        end else passed++;
        bad = 0;
        for (int i = 0; i < got_beat.size(); i++) if (got_beat[i] !== exp_beat(i, 63)) bad++;
        checks++;
        if (bad != 0) $display("FAIL wrap_beats got %0d wrong beats exp 0", bad);
        else passed++;
        checks++;
        if (iss_tap.size() != 64 || iss_tap[31] !== 5'd31 || iss_tap[32] !== 5'd0 || iss_data[63] !== 6'd63) begin
            $display("FAIL wrap_addr got n=%0d", iss_tap.size());
        end else passed++;
        checks++;
        if (iss_bias.size() != 1) $display("FAIL wrap_bias_reads got %0d exp 1", iss_bias.size());
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int bad;
        @(negedge clk);
        bus.num_out = 4'd1; bus.num_step = 6'd2; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.ld_ready, bus.busy, bus.out_valid, bus.done, bus.tap_rd_en, bus.bias_rd_en, bus.data_rd_en} !== 7'b1000000
            || {bus.tap_addr, bus.bias_addr, bus.data_addr} !== '0) begin
            $display("FAIL midrun_reset got %b",
                     {bus.ld_ready, bus.busy, bus.out_valid, bus.done, bus.tap_rd_en, bus.bias_rd_en, bus.data_rd_en});
        end else passed++;
        @(negedge clk);
        reset = 1'b0;
        run_job(1, 2, 0);
        bad = (got_beat.size() == 6 && !timed_out) ? 0 : 1;
        for (int i = 0; i < got_beat.size(); i++) if (got_beat[i] !== exp_beat(i, 2)) bad++;
        checks++;
        if (bad != 0) $display("FAIL midrun_rerun got %0d errors (beats=%0d) exp 0", bad, got_beat.size());
        else passed++;
    endtask

`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
    task automatic test_perf();
        run_job(1, 2, 2);
        checks++;
        if (timed_out !== 1'b0 || stall_at_done !== 16'd10) begin
            $display("FAIL perf_stall_cnt got %0d exp 10", stall_at_done);
        end else passed++;
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd10) $display("FAIL perf_hold_idle got %0d exp 10", stall_cnt);
        else passed++;
    endtask
`endif

    initial begin
        bus.ld_valid = 1'b0; bus.ld_sel = 2'd0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.start = 1'b0; bus.num_out = '0; bus.num_step = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_load();
        fill_memories();
        test_start_with_load();
        test_basic();
        test_backpressure();
        test_wrap();
        test_reset_mid_run();
`ifdef SIMPLE_ST0_MEM_CTRL_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
